// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Takes ALU commands from two requesters and arbitrates between them
// round-robin. Each granted command is decoded into one unit enable. The
// sequencer waits for that unit's completion flag and then returns the result
// on a valid/ready response port. A cycle counter bounds the wait, so a unit
// that never answers produces an error response.
//
// Ports
//   clk, RST                     clock, asynchronous active-low reset
//   req{0,1}_valid_i/_ready_o    command handshake per requester
//   req{0,1}_a_i/_b_i/_fun_i     operands and ALU function code
//   alu_a_o/alu_b_o/alu_fun_o    registered operands and function to the units
//   {arith,logic,cmp,shift}_en_o unit enables, at most one high
//   {arith,logic,cmp,shift}_flag_i / _out_i  unit result-valid flags and results
//   rsp_valid_o/rsp_ready_i      response handshake
//   rsp_id_o/rsp_data_o/rsp_err_o requester index, result (0 on error), timeout flag
//
// state | meaning
// IDLE  | ready offered to the granted requester, waiting for a command
// EXEC  | selected unit enabled, waiting for its flag or the timeout
// RESP  | response held on the output until rsp_ready_i
module alu_cmd_sequencer #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [3:0]        req0_fun_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [3:0]        req1_fun_i,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [3:0]        alu_fun_o,
  output logic              arith_en_o,
  output logic              logic_en_o,
  output logic              cmp_en_o,
  output logic              shift_en_o,
  input  logic              arith_flag_i,
  input  logic              logic_flag_i,
  input  logic              cmp_flag_i,
  input  logic              shift_flag_i,
  input  logic [OUT_W-1:0]  arith_out_i,
  input  logic [OUT_W-1:0]  logic_out_i,
  input  logic [OUT_W-1:0]  cmp_out_i,
  input  logic [OUT_W-1:0]  shift_out_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [OUT_W-1:0]  rsp_data_o,
  output logic              rsp_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q;
  logic              last_q;    // requester granted last; 1 after reset so req0 wins a tie
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [3:0]        en_q;      // {shift, cmp, logic, arith}
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [3:0]        alu_fun_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [OUT_W-1:0]  rsp_data_q;
  logic              rsp_err_q;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [DATA_W-1:0] acc_a;
  logic [DATA_W-1:0] acc_b;
  logic [3:0]        acc_fun;
  logic              sel_flag;
  logic [OUT_W-1:0]  sel_out;

  always_comb begin
    grant0 = req0_valid_i && (!req1_valid_i || last_q);
    grant1 = req1_valid_i && (!req0_valid_i || !last_q);
    // Ready is gated by RST so it reads 0 while reset is applied.
    req0_ready_o = RST && (state_q == IDLE) && grant0;
    req1_ready_o = RST && (state_q == IDLE) && grant1;
    accept  = req0_ready_o || req1_ready_o;
    acc_a   = req1_ready_o ? req1_a_i   : req0_a_i;
    acc_b   = req1_ready_o ? req1_b_i   : req0_b_i;
    acc_fun = req1_ready_o ? req1_fun_i : req0_fun_i;

    case (alu_fun_q[3:2])
      2'b00:   begin sel_flag = arith_flag_i; sel_out = arith_out_i; end
      2'b01:   begin sel_flag = logic_flag_i; sel_out = logic_out_i; end
      2'b10:   begin sel_flag = cmp_flag_i;   sel_out = cmp_out_i;   end
      default: begin sel_flag = shift_flag_i; sel_out = shift_out_i; end
    endcase

    // cnt_d is the number of EXEC cycles including the current one, saturating.
    cnt_d = (cnt_q == CNT_TO) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      en_q        <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            alu_a_q   <= acc_a;
            alu_b_q   <= acc_b;
            alu_fun_q <= acc_fun;
            rsp_id_q  <= req1_ready_o;
            last_q    <= req1_ready_o;
            cnt_q     <= '0;
            en_q      <= 4'b0001 << acc_fun[3:2];
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          cnt_q <= cnt_d;
          if (sel_flag) begin
            rsp_data_q  <= sel_out;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            en_q        <= '0;
            state_q     <= RESP;
          end else if (cnt_d == CNT_TO) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            en_q        <= '0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          en_q        <= '0;
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_fun_o   = alu_fun_q;
  assign arith_en_o  = en_q[0];
  assign logic_en_o  = en_q[1];
  assign cmp_en_o    = en_q[2];
  assign shift_en_o  = en_q[3];
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with simple registered unit models.
module tb_alu_cmd_sequencer;
  localparam int DW = 16;
  localparam int OW = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]    req0_fun, req1_fun;
  logic [DW-1:0] alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic          arith_en, logic_en, cmp_en, shift_en;
  logic          arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [OW-1:0] arith_out, logic_out, cmp_out, shift_out;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [OW-1:0] rsp_data;

  alu_cmd_sequencer #(.DATA_W(DW), .OUT_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .RST(RST),
    .req0_valid_i(req0_valid), .req0_ready_o(req0_ready),
    .req0_a_i(req0_a), .req0_b_i(req0_b), .req0_fun_i(req0_fun),
    .req1_valid_i(req1_valid), .req1_ready_o(req1_ready),
    .req1_a_i(req1_a), .req1_b_i(req1_b), .req1_fun_i(req1_fun),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fun_o(alu_fun),
    .arith_en_o(arith_en), .logic_en_o(logic_en), .cmp_en_o(cmp_en), .shift_en_o(shift_en),
    .arith_flag_i(arith_flag), .logic_flag_i(logic_flag), .cmp_flag_i(cmp_flag), .shift_flag_i(shift_flag),
    .arith_out_i(arith_out), .logic_out_i(logic_out), .cmp_out_i(cmp_out), .shift_out_i(shift_out),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
  );

  // Unit models: flag and result one clock after the enable, cleared when the enable drops.
  logic [3:0] en;
  logic [3:0] flag_q = 4'b0000;
  logic [3:0] inj;
  logic       arith_dis;
  assign en = {shift_en, cmp_en, logic_en, arith_en};

  function automatic logic [15:0] shf(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
    case (f[1:0])
      2'b00:   shf = a >> 1;
      2'b01:   shf = a << 1;
      2'b10:   shf = a >> 2;
      default: shf = b << 1;
    endcase
  endfunction

  always @(posedge clk) begin
    flag_q    <= en & {3'b111, ~arith_dis};
    arith_out <= en[0] ? alu_a + alu_b : 16'h0;
    logic_out <= en[1] ? alu_a ^ alu_b : 16'h0;
    cmp_out   <= en[2] ? {15'b0, alu_a > alu_b} : 16'h0;
    shift_out <= en[3] ? shf(alu_fun, alu_a, alu_b) : 16'h0;
  end
  assign arith_flag = flag_q[0] | inj[0];
  assign logic_flag = flag_q[1] | inj[1];
  assign cmp_flag   = flag_q[2] | inj[2];
  assign shift_flag = flag_q[3] | inj[3];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 12 && !rsp_valid; i++) tick();
    chk({tag, "_rspv"}, {31'b0, rsp_valid}, 32'd1);
  endtask

  // a=0x1234, b=0x0F0F for every code: a+b, a^b, a>b, then the four shift forms.
  logic [15:0] exp_tab [16] = '{16'h2143, 16'h2143, 16'h2143, 16'h2143,
                               16'h1D3B, 16'h1D3B, 16'h1D3B, 16'h1D3B,
                               16'h0001, 16'h0001, 16'h0001, 16'h0001,
                               16'h091A, 16'h2468, 16'h048D, 16'h1E1E};

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_fun = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_fun = '0;
    rsp_ready = 1'b0; inj = 4'b0; arith_dis = 1'b0;

    // Reset values, with req0 valid to confirm ready stays low in reset
    #12;
    chk("rst_ctl", {24'b0, en, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready}, 32'd0);
    chk("rst_data", {rsp_data, alu_a}, 32'd0);
    chk("rst_alu", {12'b0, alu_b, alu_fun}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0;
    RST = 1'b1;
    tick();

    // Single shift command: accept c0, shift_en c1-c2, response c3
    req0_valid = 1'b1; req0_a = 16'h0006; req0_b = 16'h0000; req0_fun = 4'b1100;
    #1;
    chk("t1_ready_c0", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("t1_en_c1", {28'b0, en}, 32'h8);
    chk("t1_rspv_c1", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t1_en_c2", {28'b0, en}, 32'h8);
    chk("t1_rspv_c2", {31'b0, rsp_valid}, 32'd0);
    tick();
    chk("t1_en_c3", {28'b0, en}, 32'h0);
    chk("t1_rspv_c3", {31'b0, rsp_valid}, 32'd1);
    chk("t1_data", {16'b0, rsp_data}, 32'h0003);
    chk("t1_id_err", {30'b0, rsp_id, rsp_err}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    chk("t1_rspv_c4", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    // Reset restores the pointer to favour req0
    @(negedge clk); RST = 1'b0;
    @(negedge clk); RST = 1'b1;
    tick();

    // Simultaneous requests held valid: alternation over 5 pairs
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0000; req0_fun = 4'b1101;
    req1_valid = 1'b1; req1_a = 16'h0000; req1_b = 16'h0004; req1_fun = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("t2_first_grant", {30'b0, req0_ready, req1_ready}, 32'b10);
    for (int k = 0; k < 10; k++) begin
      wait_rsp($sformatf("t2_k%0d", k));
      chk($sformatf("t2_id_k%0d", k), {31'b0, rsp_id}, k % 2);
      chk($sformatf("t2_data_k%0d", k), {16'b0, rsp_data}, (k % 2 == 1) ? 32'h0008 : 32'h0002);
      chk($sformatf("t2_err_k%0d", k), {31'b0, rsp_err}, 32'd0);
      if (k == 9) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
      chk($sformatf("t2_drop_k%0d", k), {31'b0, rsp_valid}, 32'd0);
      if (k < 9)
        chk($sformatf("t2_next_grant_k%0d", k), {30'b0, req0_ready, req1_ready},
            (k % 2 == 1) ? 32'b10 : 32'b01);
    end
    rsp_ready = 1'b0;

    // Timeout: arith flag held low, enable for TIMEOUT cycles then error response
    arith_dis = 1'b1;
    req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0005; req1_fun = 4'b0000;
    #1;
    chk("t3_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    for (int i = 1; i <= TO; i++) begin
      chk($sformatf("t3_en_c%0d", i), {28'b0, en}, 32'h1);
      chk($sformatf("t3_rspv_c%0d", i), {31'b0, rsp_valid}, 32'd0);
      tick();
    end
    chk("t3_rspv", {31'b0, rsp_valid}, 32'd1);
    chk("t3_err", {31'b0, rsp_err}, 32'd1);
    chk("t3_data", {16'b0, rsp_data}, 32'd0);
    chk("t3_id", {31'b0, rsp_id}, 32'd1);
    chk("t3_en_off", {28'b0, en}, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    arith_dis = 1'b0;

    // Backpressure: response held 5 cycles while req1 waits
    req0_valid = 1'b1; req0_a = 16'h00F0; req0_b = 16'h0FF0; req0_fun = 4'b0100;
    #1;
    chk("t4_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0003; req1_b = 16'h0002; req1_fun = 4'b1000;
    wait_rsp("t4");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold_v%0d", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("t4_hold_d%0d", i), {16'b0, rsp_data}, 32'h0F00);
      chk($sformatf("t4_hold_id%0d", i), {31'b0, rsp_id}, 32'd0);
      chk($sformatf("t4_noacc%0d", i), {28'b0, req1_ready, 1'b0, alu_fun[3:2]}, 32'b0001);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_idle_rspv", {31'b0, rsp_valid}, 32'd0);
    chk("t4_idle_ready1", {31'b0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    wait_rsp("t4b");
    chk("t4b_data", {16'b0, rsp_data}, 32'h0001);
    chk("t4b_id", {31'b0, rsp_id}, 32'd1);
    tick();

    // Reset mid-EXEC of a logic command
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h00FF; req0_fun = 4'b0101;
    #1;
    chk("t5_ready", {31'b0, req0_ready}, 32'd1);
    tick();
    chk("t5_en_c1", {28'b0, en}, 32'h2);
    #2;
    RST = 1'b0;
    #1;
    chk("t5_rst_ctl", {24'b0, en, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready}, 32'd0);
    chk("t5_rst_data", {rsp_data, alu_a}, 32'd0);
    chk("t5_rst_alu", {12'b0, alu_b, alu_fun}, 32'd0);
    @(negedge clk);
    RST = 1'b1;
    req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_fun = 4'b0101;
    #1;
    chk("t5_ready_after", {31'b0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    wait_rsp("t5b");
    chk("t5b_data", {16'b0, rsp_data}, 32'h0FF0);
    chk("t5b_id_err", {30'b0, rsp_id, rsp_err}, 32'd0);
    tick();

    // Sweep all function codes with foreign flags forced high
    for (int i = 0; i < 16; i++) begin
      logic [3:0] oh;
      oh = 4'b0001 << i[3:2];
      inj = ~oh;
      req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0F0F; req0_fun = i[3:0];
      #1;
      chk($sformatf("t6_ready_f%0d", i), {31'b0, req0_ready}, 32'd1);
      tick();
      req0_valid = 1'b0;
      chk($sformatf("t6_en_c1_f%0d", i), {28'b0, en}, {28'b0, oh});
      chk($sformatf("t6_rspv_c1_f%0d", i), {31'b0, rsp_valid}, 32'd0);
      tick();
      chk($sformatf("t6_en_c2_f%0d", i), {28'b0, en}, {28'b0, oh});
      chk($sformatf("t6_rspv_c2_f%0d", i), {31'b0, rsp_valid}, 32'd0);
      tick();
      chk($sformatf("t6_rspv_c3_f%0d", i), {31'b0, rsp_valid}, 32'd1);
      chk($sformatf("t6_data_f%0d", i), {16'b0, rsp_data}, {16'b0, exp_tab[i]});
      chk($sformatf("t6_err_f%0d", i), {31'b0, rsp_err}, 32'd0);
      tick();
      inj = 4'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
